// File: rtl/collatz_stream_gen.sv
// Collatz sequence stream source: loads a seed on start and emits n, ..., 1 under a
// valid/ready handshake, reporting beats transferred and arithmetic overflow.
module collatz_stream_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [WIDTH+1:0] w_triple;
    logic             w_xfer;
    logic             w_is_one;
    logic             w_odd_ovf;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // 3x+1 built as x + 2x + 1 with two guard bits so overflow is visible.
    assign w_triple  = {2'b00, r_data} + {1'b0, r_data, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_odd_ovf = r_data[0] && (w_triple[WIDTH+1:WIDTH] != 2'b00);
    assign w_is_one  = (r_data == WIDTH'(1));
    assign w_xfer    = r_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        if (n == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= S_EMIT;
                            r_data  <= n;
                            r_valid <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        r_count <= sat_inc(r_count);
                        if (w_is_one) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (!r_data[0]) begin
                            r_data <= r_data >> 1;
                        end else if (w_odd_ovf) begin
                            // The out-of-range element is dropped, never presented.
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_ovf   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_data <= w_triple[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_collatz_stream_gen.sv
// Randomized and directed checks of collatz_stream_gen against a queue-based
// Collatz reference model; a 32-bit and an 8-bit instance are exercised.
module tb_collatz_stream_gen;

    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [31:0] n_in  = '0;
    logic        ready = 1'b0;
    logic [31:0] data_out;
    logic        valid, done, overflow;
    logic [15:0] count;

    logic        start8 = 1'b0;
    logic [7:0]  n8     = '0;
    logic        ready8 = 1'b1;
    logic [7:0]  data8;
    logic        valid8, done8, ovf8;
    logic [15:0] count8;

    int n_tests = 0;
    int n_fail  = 0;

    longint exp_q[$];
    bit     exp_ovf = 1'b0;
    int     beats   = 0;
    bit     active  = 1'b0;

    longint tmp_q[$];
    bit     tmp_ovf;

    collatz_stream_gen #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n_in), .ready(ready),
        .data_out(data_out), .valid(valid), .done(done), .count(count), .overflow(overflow)
    );

    collatz_stream_gen #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8), .ready(ready8),
        .data_out(data8), .valid(valid8), .done(done8), .count(count8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: the full sequence as a list, stopping at 1 or before the first
    // element that does not fit in w bits.
    task automatic build_model(input longint nn, input int w);
        longint x;
        longint lim;
        tmp_q.delete();
        tmp_ovf = 1'b0;
        lim = (longint'(1) << w) - 1;
        x = nn;
        if (nn == 0) return;
        forever begin
            tmp_q.push_back(x);
            if (x == 1) break;
            if (x % 2 == 0) x = x / 2;
            else begin
                x = 3 * x + 1;
                if (x > lim) begin
                    tmp_ovf = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Cycle-by-cycle compare of the 32-bit instance against the model.
    always @(negedge clk) begin
        if (active && !rst) begin
            if (exp_q.size() != 0) begin
                chk("valid_emit", valid, 1);
                chk("data_out", data_out, exp_q[0]);
                chk("done_emit", done, 0);
                chk("count_emit", count, beats);
                if (ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end else begin
                chk("valid_done", valid, 0);
                chk("done_done", done, 1);
                chk("count_done", count, beats);
                chk("overflow_done", overflow, exp_ovf);
            end
        end
    end

    function automatic logic ready_val(input int mode, input int idx);
        logic [5:0] pat;
        pat = 6'b101001;  // idx 0..5 -> 1,0,0,1,0,1
        case (mode)
            0:       return 1'b1;
            1:       return pat[idx % 6];
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic do_start(input longint nn, input int mode);
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = nn[31:0];
        @(posedge clk); #1;
        start = 1'b0;
        build_model(nn, 32);
        exp_q   = tmp_q;
        exp_ovf = tmp_ovf;
        beats   = 0;
        active  = 1'b1;
        ready   = ready_val(mode, 0);
    endtask

    task automatic run(input longint nn, input int mode, input bit mid_start);
        int idx;
        do_start(nn, mode);
        idx = 0;
        while (exp_q.size() != 0 && idx < BUDGET) begin
            @(posedge clk); #1;
            idx++;
            ready = ready_val(mode, idx);
            if (mid_start && idx == 5) begin
                start = 1'b1;
                n_in  = 32'd27;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (idx >= BUDGET) chk("run_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run8(input longint nn);
        @(posedge clk); #1;
        start8 = 1'b1;
        n8     = nn[7:0];
        @(posedge clk); #1;
        start8 = 1'b0;
        build_model(nn, 8);
        for (int i = 0; i < tmp_q.size(); i++) begin
            @(negedge clk);
            chk("w8_valid", valid8, 1);
            chk("w8_data", data8, tmp_q[i]);
            chk("w8_count", count8, i);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w8_valid_end", valid8, 0);
        chk("w8_done", done8, 1);
        chk("w8_overflow", ovf8, tmp_ovf);
        chk("w8_count_end", count8, tmp_q.size());
    endtask

    initial begin
        longint lit6[9];
        longint rn;
        int     idx;
        lit6 = '{6, 3, 10, 5, 16, 8, 4, 2, 1};

        // Pin the model to hand-worked sequences.
        build_model(6, 32);
        chk("model6_len", tmp_q.size(), 9);
        chk("model6_ovf", tmp_ovf, 0);
        for (int i = 0; i < 9 && i < tmp_q.size(); i++) chk("model6_elem", tmp_q[i], lit6[i]);
        build_model(255, 8);
        chk("model255_len", tmp_q.size(), 1);
        chk("model255_ovf", tmp_ovf, 1);
        build_model(27, 8);
        chk("model27_len", tmp_q.size(), 12);
        chk("model27_last", tmp_q[tmp_q.size()-1], 107);
        build_model(3, 32);
        chk("model3_len", tmp_q.size(), 8);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid8", valid8, 0);

        run(6, 0, 1'b0);
        chk("n6_count", count, 9);
        chk("n6_ovf", overflow, 0);
        chk("n6_done", done, 1);

        run(1, 0, 1'b0);
        chk("n1_count", count, 1);
        chk("n1_done", done, 1);

        run(0, 0, 1'b0);
        chk("n0_count", count, 0);
        chk("n0_done", done, 1);
        chk("n0_valid", valid, 0);

        run(6, 1, 1'b1);
        chk("n6bp_count", count, 9);
        chk("n6bp_ovf", overflow, 0);

        run8(255);
        chk("w8_255_data", data8, 255);
        chk("w8_255_cnt", count8, 1);
        run8(27);
        run8(7);

        // Reset in the middle of a run, right after the 4th transfer.
        do_start(6, 0);
        idx = 0;
        while (beats < 4 && idx < BUDGET) begin
            @(posedge clk); #1;
            idx++;
        end
        if (idx >= BUDGET) chk("rst_mid_timeout", 1, 0);
        @(posedge clk); #1;
        rst    = 1'b1;
        active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", count, 0);
        run(3, 0, 1'b0);
        chk("n3_count", count, 8);
        chk("n3_ovf", overflow, 0);

        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 3))
                0:       rn = longint'($urandom_range(1, 2000));
                1:       rn = longint'($urandom);
                2:       rn = longint'(32'hFFFF_FFFF - $urandom_range(0, 64));
                default: rn = longint'($urandom_range(0, 3));
            endcase
            run(rn, 2, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
